// File: rtl/ripple_count_monitor_if.sv
// Bus between a ripple-counter source and its synchronous monitor.
// The master drives the raw count, target and arm; the slave returns the filtered status.
interface ripple_count_monitor_if #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned TALLY_W = 8
);
  logic [WIDTH-1:0]   q_in;
  logic [WIDTH-1:0]   target;
  logic               arm;
  logic [WIDTH-1:0]   stable_q;
  logic               busy;
  logic               hit;
  logic               wrap;
  logic [TALLY_W-1:0] hit_count;

  modport master (
    output q_in, target, arm,
    input  stable_q, busy, hit, wrap, hit_count
  );

  modport slave (
    input  q_in, target, arm,
    output stable_q, busy, hit, wrap, hit_count
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Resynchronises an asynchronous ripple-counter value, filters transient codes,
// and reports target hits, wrap-around and a saturating hit tally.
module ripple_count_monitor #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned TALLY_W = 8
) (
  input  logic                clk,
  input  logic                clear,
  ripple_count_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   s1, s2, s3;
  logic [WIDTH-1:0]   stable_r;
  logic               wrap_r;
  logic [TALLY_W-1:0] tally_r;

  logic upd;
  logic match;
  logic wrap_d;
  logic tally_inc;

  // A code reaches stable_q only after two identical consecutive samples.
  always_comb begin
    upd    = (s2 == s3) && (s2 != stable_r);
    match  = upd && (s2 == mon.target);
    wrap_d = upd && (((stable_r == '0) && (s2 == '1)) ||
                     ((stable_r == '1) && (s2 == '0)));
  end

  always_comb begin
    state_d   = state_q;
    tally_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (mon.arm) state_d = ARMED;
      end
      ARMED: begin
        // A match wins over arm falling on the same edge.
        if (match) begin
          state_d   = HIT;
          tally_inc = (tally_r != '1);
        end else if (!mon.arm) begin
          state_d = IDLE;
        end
      end
      HIT: begin
        state_d = mon.arm ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      stable_r <= '0;
      wrap_r   <= 1'b0;
      tally_r  <= '0;
      state_q  <= IDLE;
    end else begin
      s1      <= mon.q_in;
      s2      <= s1;
      s3      <= s2;
      if (s2 == s3) stable_r <= s2;
      wrap_r  <= wrap_d;
      if (tally_inc) tally_r <= tally_r + 1'b1;
      state_q <= state_d;
    end
  end

  assign mon.stable_q  = stable_r;
  assign mon.busy      = (state_q != IDLE);
  assign mon.hit       = (state_q == HIT);
  assign mon.wrap      = wrap_r;
  assign mon.hit_count = tally_r;

endmodule
